// File: rtl/uart_tx_buffered_if.sv
// Byte-write handshake and serial-line status bundle
// for the buffered UART transmitter.
interface uart_tx_buffered_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          i_TX_DV;
  logic [7:0]    i_TX_Byte;
  logic          o_Full;
  logic [CW-1:0] o_Count;
  logic          o_TX_Active;
  logic          o_TX_Serial;
  logic          o_TX_Done;

  modport master (
    output i_TX_DV,
    output i_TX_Byte,
    input  o_Full,
    input  o_Count,
    input  o_TX_Active,
    input  o_TX_Serial,
    input  o_TX_Done
  );

  modport slave (
    input  i_TX_DV,
    input  i_TX_Byte,
    output o_Full,
    output o_Count,
    output o_TX_Active,
    output o_TX_Serial,
    output o_TX_Done
  );
endinterface

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter fed by a small circular FIFO;
// frames are sent back-to-back with a one-cycle gap.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input logic              i_Clk,
  input logic              i_Rst_L,
  uart_tx_buffered_if.slave tx
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST =
    BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_FULL =
    CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_n;
  logic          full;
  logic          push;
  logic          pop;

  state_t        state;
  state_t        state_n;
  logic [BW-1:0] baud;
  logic [BW-1:0] baud_n;
  logic [2:0]    idx;
  logic [2:0]    idx_n;
  logic [7:0]    shift;
  logic          serial;
  logic          serial_n;
  logic          active;
  logic          active_n;
  logic          done;
  logic          done_n;

  // A full FIFO drops the write even if a pop frees a slot.
  assign push = tx.i_TX_DV && !full;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_n = count;
    unique case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // Storage array; stale entries are harmless after reset.
  always_ff @(posedge i_Clk) begin
    if (push)
      mem[wr_ptr] <= tx.i_TX_Byte;
  end

  // FIFO pointers, occupancy and registered full flag.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      count <= count_n;
      full  <= (count_n == CNT_FULL);
    end
  end

  // Serializer state and registered line outputs.
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state  <= IDLE;
      baud   <= '0;
      idx    <= '0;
      shift  <= '0;
      serial <= 1'b1;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      baud   <= baud_n;
      idx    <= idx_n;
      serial <= serial_n;
      active <= active_n;
      done   <= done_n;
      if (pop)
        shift <= mem[rd_ptr];
    end
  end

  // Next state and next registered line values.
  always_comb begin
    state_n  = state;
    baud_n   = baud;
    idx_n    = idx;
    serial_n = serial;
    active_n = active;
    done_n   = 1'b0;
    pop      = 1'b0;
    unique case (state)
      IDLE: begin
        baud_n   = '0;
        idx_n    = '0;
        serial_n = 1'b1;
        active_n = 1'b0;
        if (count != '0) begin
          pop      = 1'b1;
          state_n  = START;
          serial_n = 1'b0;
          active_n = 1'b1;
        end
      end
      START: begin
        serial_n = 1'b0;
        if (baud == BAUD_LAST) begin
          state_n  = DATA;
          baud_n   = '0;
          idx_n    = '0;
          serial_n = shift[0];
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      DATA: begin
        if (baud == BAUD_LAST) begin
          baud_n = '0;
          if (idx == 3'd7) begin
            state_n  = STOP;
            serial_n = 1'b1;
          end else begin
            idx_n    = idx + 3'd1;
            serial_n = shift[idx + 3'd1];
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      STOP: begin
        serial_n = 1'b1;
        if (baud == BAUD_LAST) begin
          state_n  = IDLE;
          baud_n   = '0;
          active_n = 1'b0;
          done_n   = 1'b1;
        end else begin
          baud_n = baud + BW'(1);
        end
      end
      default: begin
        state_n  = IDLE;
        baud_n   = '0;
        serial_n = 1'b1;
        active_n = 1'b0;
      end
    endcase
  end

  assign tx.o_Full      = full;
  assign tx.o_Count     = count;
  assign tx.o_TX_Active = active;
  assign tx.o_TX_Serial = serial;
  assign tx.o_TX_Done   = done;
endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered with
// CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_uart_tx_buffered;
  localparam int CPB = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_l = 1'b0;

  uart_tx_buffered_if #(.FIFO_DEPTH(DEPTH)) tx ();

  uart_tx_buffered #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clk(clk),
    .i_Rst_L(rst_l),
    .tx(tx)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_fail = 0;

  int n_done = 0;
  int peak = 0;
  logic rx_busy = 1'b0;
  int rx_cnt = 0;
  int rx_gap = 0;
  int rx_stop_err = 0;
  logic [7:0] rx_sh = '0;
  logic [7:0] rx_q [$];
  int gap_q [$];

  // Line monitor: counts done pulses, tracks peak occupancy,
  // and decodes frames by sampling mid-bit.
  always @(negedge clk) begin
    if (tx.o_TX_Done)
      n_done++;
    if (int'(tx.o_Count) > peak)
      peak = int'(tx.o_Count);
    if (rx_busy) begin
      rx_cnt++;
      if (rx_cnt >= CPB + CPB/2 &&
          rx_cnt <= 8*CPB + CPB/2 &&
          (rx_cnt - CPB - CPB/2) % CPB == 0)
        rx_sh[(rx_cnt - CPB - CPB/2) / CPB] = tx.o_TX_Serial;
      if (rx_cnt == 9*CPB + CPB/2 && tx.o_TX_Serial !== 1'b1)
        rx_stop_err++;
      if (rx_cnt == 10*CPB - 1) begin
        rx_q.push_back(rx_sh);
        rx_busy = 1'b0;
      end
    end else if (tx.o_TX_Serial === 1'b0) begin
      rx_busy = 1'b1;
      rx_cnt = 0;
      gap_q.push_back(rx_gap);
      rx_gap = 0;
    end else begin
      rx_gap++;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mon_clear();
    rx_busy = 1'b0;
    rx_cnt = 0;
    rx_gap = 0;
    rx_stop_err = 0;
    rx_q.delete();
    gap_q.delete();
    n_done = 0;
    peak = 0;
  endtask

  task automatic do_reset(input int n);
    rst_l = 1'b0;
    tx.i_TX_DV = 1'b0;
    repeat (n) tick();
    rst_l = 1'b1;
    mon_clear();
  endtask

  task automatic write(input logic [7:0] b);
    tx.i_TX_DV = 1'b1;
    tx.i_TX_Byte = b;
    tick();
    tx.i_TX_DV = 1'b0;
  endtask

  task automatic wait_ndone(input string tag, input int target,
                            input int lim);
    for (int i = 0; i < lim && n_done < target; i++)
      tick();
    repeat (2) tick();
    chk(tag, 64'(n_done), 64'(target));
  endtask

  task automatic wait_done_pulse(input string tag);
    int k;
    k = 0;
    while (tx.o_TX_Done !== 1'b1 && k < 100) begin
      tick();
      k++;
    end
    chk(tag, 64'(tx.o_TX_Done), 64'd1);
  endtask

  initial begin
    logic bad;
    logic act_ok;
    logic dn_mid;
    logic [39:0] line;
    logic [39:0] exp40;
    logic [9:0] exp10;

    tx.i_TX_DV = 1'b0;
    tx.i_TX_Byte = '0;

    // Reset values and idle stability
    do_reset(3);
    chk("rst_serial", 64'(tx.o_TX_Serial), 64'd1);
    chk("rst_active", 64'(tx.o_TX_Active), 64'd0);
    chk("rst_done", 64'(tx.o_TX_Done), 64'd0);
    chk("rst_full", 64'(tx.o_Full), 64'd0);
    chk("rst_count", 64'(tx.o_Count), 64'd0);
    bad = 1'b0;
    repeat (100) begin
      tick();
      if (tx.o_TX_Serial !== 1'b1 || tx.o_TX_Active !== 1'b0 ||
          tx.o_TX_Done !== 1'b0 || tx.o_Full !== 1'b0 ||
          tx.o_Count !== '0)
        bad = 1'b1;
    end
    chk("idle_stable", 64'(bad), 64'd0);

    // Single byte 0xA5: start,1,0,1,0,0,1,0,1,stop
    exp10 = 10'b1101001010;
    for (int i = 0; i < 40; i++)
      exp40[i] = exp10[i / CPB];
    write(8'hA5);
    chk("a5_count_e1", 64'(tx.o_Count), 64'd1);
    chk("a5_serial_e1", 64'(tx.o_TX_Serial), 64'd1);
    tick();
    chk("a5_start_lat", 64'(tx.o_TX_Serial), 64'd0);
    chk("a5_count_e2", 64'(tx.o_Count), 64'd0);
    act_ok = 1'b1;
    dn_mid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      line[i] = tx.o_TX_Serial;
      if (tx.o_TX_Active !== 1'b1) act_ok = 1'b0;
      if (tx.o_TX_Done !== 1'b0) dn_mid = 1'b1;
      tick();
    end
    chk("a5_line", 64'(line), 64'(exp40));
    chk("a5_active40", 64'(act_ok), 64'd1);
    chk("a5_done_early", 64'(dn_mid), 64'd0);
    chk("a5_end_active", 64'(tx.o_TX_Active), 64'd0);
    chk("a5_end_done", 64'(tx.o_TX_Done), 64'd1);
    chk("a5_end_serial", 64'(tx.o_TX_Serial), 64'd1);
    tick();
    chk("a5_done_1cyc", 64'(tx.o_TX_Done), 64'd0);
    chk("a5_rx", 64'(rx_q[0]), 64'hA5);

    // Back-to-back writes
    do_reset(1);
    write(8'h01);
    write(8'h80);
    write(8'hFF);
    write(8'h00);
    wait_ndone("b2b_ndone", 4, 300);
    chk("b2b_peak", 64'(peak), 64'd3);
    chk("b2b_nrx", 64'(rx_q.size()), 64'd4);
    chk("b2b_rx0", 64'(rx_q[0]), 64'h01);
    chk("b2b_rx1", 64'(rx_q[1]), 64'h80);
    chk("b2b_rx2", 64'(rx_q[2]), 64'hFF);
    chk("b2b_rx3", 64'(rx_q[3]), 64'h00);
    chk("b2b_gap1", 64'(gap_q[1]), 64'd1);
    chk("b2b_gap2", 64'(gap_q[2]), 64'd1);
    chk("b2b_gap3", 64'(gap_q[3]), 64'd1);
    chk("b2b_stop", 64'(rx_stop_err), 64'd0);

    // Overflow: 0x15 is dropped
    do_reset(1);
    write(8'h10);
    write(8'h11);
    write(8'h12);
    write(8'h13);
    write(8'h14);
    chk("ovf_full_e5", 64'(tx.o_Full), 64'd1);
    write(8'h15);
    chk("ovf_count_e6", 64'(tx.o_Count), 64'd4);
    wait_ndone("ovf_ndone", 5, 400);
    chk("ovf_nrx", 64'(rx_q.size()), 64'd5);
    for (int i = 0; i < 5; i++)
      chk("ovf_rx", 64'(rx_q[i]), 64'(8'h10 + i));
    chk("ovf_count_end", 64'(tx.o_Count), 64'd0);
    chk("ovf_full_end", 64'(tx.o_Full), 64'd0);

    // Write on the pop edge, normal and full
    do_reset(1);
    write(8'h21);
    write(8'h22);
    write(8'h23);
    chk("sim_count2", 64'(tx.o_Count), 64'd2);
    wait_done_pulse("sim_done1");
    chk("sim_idle_cnt", 64'(tx.o_Count), 64'd2);
    write(8'h24);
    chk("sim_wp_count", 64'(tx.o_Count), 64'd2);
    chk("sim_wp_start", 64'(tx.o_TX_Serial), 64'd0);
    write(8'h25);
    write(8'h26);
    chk("sim_full", 64'(tx.o_Full), 64'd1);
    wait_done_pulse("sim_done2");
    write(8'h27);
    chk("sim_fp_count", 64'(tx.o_Count), 64'(DEPTH - 1));
    chk("sim_fp_full", 64'(tx.o_Full), 64'd0);
    wait_ndone("sim_ndone", 6, 400);
    chk("sim_nrx", 64'(rx_q.size()), 64'd6);
    for (int i = 0; i < 6; i++)
      chk("sim_rx", 64'(rx_q[i]), 64'(8'h21 + i));

    // Reset during DATA bit 3 with two bytes buffered
    do_reset(1);
    write(8'h5A);
    write(8'h6B);
    write(8'h7C);
    chk("mid_count2", 64'(tx.o_Count), 64'd2);
    repeat (16) tick();
    chk("mid_active", 64'(tx.o_TX_Active), 64'd1);
    rst_l = 1'b0;
    tick();
    rst_l = 1'b1;
    chk("mid_serial", 64'(tx.o_TX_Serial), 64'd1);
    chk("mid_count0", 64'(tx.o_Count), 64'd0);
    chk("mid_inactive", 64'(tx.o_TX_Active), 64'd0);
    chk("mid_nodone", 64'(tx.o_TX_Done), 64'd0);
    mon_clear();
    bad = 1'b0;
    repeat (200) begin
      tick();
      if (tx.o_TX_Serial !== 1'b1 || tx.o_TX_Active !== 1'b0)
        bad = 1'b1;
    end
    chk("mid_quiet", 64'(bad), 64'd0);
    chk("mid_ndone", 64'(n_done), 64'd0);
    chk("mid_nrx", 64'(rx_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
